// File: rtl/ht_vote_list_if.sv
// Command/result bundle for ht_vote_list: the master issues commands, the slave (the list engine) returns results.
// Commands are level inputs sampled only while the engine is idle; results hold until the next completion.
interface ht_vote_list_if #(
  parameter int RHO_W  = 10,
  parameter int CNT_W  = 12,
  parameter int ADDR_W = 8,
  parameter int LIST_W = 2
);
  logic [LIST_W-1:0]             list_i;
  logic [RHO_W-1:0]              rho_i;
  logic                          append_i;
  logic                          search_i;
  logic                          clear_i;
  logic                          busy_o;
  logic                          done_o;
  logic                          append_o;
  logic                          found_o;
  logic                          full_o;
  logic [CNT_W+RHO_W+ADDR_W-1:0] node_o;

  modport master (
    output list_i, rho_i, append_i, search_i, clear_i,
    input  busy_o, done_o, append_o, found_o, full_o, node_o
  );

  modport slave (
    input  list_i, rho_i, append_i, search_i, clear_i,
    output busy_o, done_o, append_o, found_o, full_o, node_o
  );
endinterface

// File: rtl/ht_vote_list.sv
// N_LIST Hough vote lists over a shared node pool; latency = walk length + 1..2 cycles (clear: 2).
// No backpressure: commands arriving while busy_o is high are dropped.
module ht_vote_list #(
  parameter int RHO_W  = 10,
  parameter int CNT_W  = 12,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8,
  parameter int N_LIST = 4,
  parameter int LIST_W = 2
) (
  input logic           clk,
  input logic           rstn,
  ht_vote_list_if.slave bus
);

  localparam int NODE_W = CNT_W + RHO_W + ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WALK,
    S_UPDATE,
    S_ALLOC,
    S_DONE,
    S_CLEAR
  } state_t;

  state_t              state;
  logic [LIST_W-1:0]   list_q;
  logic [RHO_W-1:0]    rho_q;
  logic                is_append;
  logic [ADDR_W-1:0]   cur;
  logic [ADDR_W-1:0]   head [N_LIST];
  logic [N_LIST-1:0]   head_vld;
  logic [ADDR_W:0]     free_ptr;

  // Result staged during the command, published to the ports in DONE.
  logic                res_found;
  logic                res_append;
  logic                res_full;
  logic [NODE_W-1:0]   res_node;

  logic                busy_q;
  logic                done_q;
  logic                append_q;
  logic                found_q;
  logic                full_q;
  logic [NODE_W-1:0]   node_q;

  logic [CNT_W-1:0]    cnt_mem [DEPTH];
  logic [RHO_W-1:0]    rho_mem [DEPTH];
  logic [ADDR_W-1:0]   nxt_mem [DEPTH];

  logic [CNT_W-1:0]    cur_cnt;
  logic [RHO_W-1:0]    cur_rho;
  logic [ADDR_W-1:0]   cur_nxt;
  logic [CNT_W-1:0]    cnt_inc;
  logic [ADDR_W-1:0]   free_idx;
  logic                pool_full;

  assign cur_cnt   = cnt_mem[cur];
  assign cur_rho   = rho_mem[cur];
  assign cur_nxt   = nxt_mem[cur];
  assign cnt_inc   = (&cur_cnt) ? cur_cnt : cur_cnt + CNT_W'(1);
  assign free_idx  = free_ptr[ADDR_W-1:0];
  assign pool_full = (free_ptr == (ADDR_W+1)'(DEPTH));

  // Pool storage is not reset; writes only happen in UPDATE/ALLOC, which reset forces out of.
  always_ff @(posedge clk) begin
    if (state == S_UPDATE) begin
      cnt_mem[cur] <= cnt_inc;
    end
    if (state == S_ALLOC && !pool_full) begin
      cnt_mem[free_idx] <= CNT_W'(1);
      rho_mem[free_idx] <= rho_q;
      nxt_mem[free_idx] <= free_idx;
      if (head_vld[list_q]) begin
        nxt_mem[cur] <= free_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      list_q     <= '0;
      rho_q      <= '0;
      is_append  <= 1'b0;
      cur        <= '0;
      head_vld   <= '0;
      free_ptr   <= '0;
      res_found  <= 1'b0;
      res_append <= 1'b0;
      res_full   <= 1'b0;
      res_node   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      append_q   <= 1'b0;
      found_q    <= 1'b0;
      full_q     <= 1'b0;
      node_q     <= '0;
      for (int i = 0; i < N_LIST; i++) begin
        head[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.clear_i) begin
            busy_q <= 1'b1;
            state  <= S_CLEAR;
          end else if (bus.append_i || bus.search_i) begin
            busy_q    <= 1'b1;
            list_q    <= bus.list_i;
            rho_q     <= bus.rho_i;
            is_append <= bus.append_i;
            cur       <= head[bus.list_i];
            // An empty list skips the walk entirely.
            if (head_vld[bus.list_i]) begin
              state <= S_WALK;
            end else if (bus.append_i) begin
              state <= S_ALLOC;
            end else begin
              res_found  <= 1'b0;
              res_append <= 1'b0;
              res_full   <= 1'b0;
              res_node   <= '0;
              state      <= S_DONE;
            end
          end
        end

        S_WALK: begin
          if (cur_rho == rho_q) begin
            if (is_append) begin
              state <= S_UPDATE;
            end else begin
              res_found  <= 1'b1;
              res_append <= 1'b0;
              res_full   <= 1'b0;
              res_node   <= {cur_cnt, cur_rho, cur_nxt};
              state      <= S_DONE;
            end
          end else if (cur_nxt == cur) begin
            // Tail reached without a match; cur stays on the tail for linking.
            if (is_append) begin
              state <= S_ALLOC;
            end else begin
              res_found  <= 1'b0;
              res_append <= 1'b0;
              res_full   <= 1'b0;
              res_node   <= '0;
              state      <= S_DONE;
            end
          end else begin
            cur <= cur_nxt;
          end
        end

        S_UPDATE: begin
          res_found  <= 1'b1;
          res_append <= 1'b0;
          res_full   <= 1'b0;
          res_node   <= {cnt_inc, cur_rho, cur_nxt};
          state      <= S_DONE;
        end

        S_ALLOC: begin
          res_found <= 1'b0;
          if (pool_full) begin
            res_append <= 1'b0;
            res_full   <= 1'b1;
            res_node   <= '0;
          end else begin
            res_append <= 1'b1;
            res_full   <= 1'b0;
            res_node   <= {CNT_W'(1), rho_q, free_idx};
            free_ptr   <= free_ptr + (ADDR_W+1)'(1);
            if (!head_vld[list_q]) begin
              head[list_q]     <= free_idx;
              head_vld[list_q] <= 1'b1;
            end
          end
          state <= S_DONE;
        end

        S_CLEAR: begin
          head_vld   <= '0;
          free_ptr   <= '0;
          res_found  <= 1'b0;
          res_append <= 1'b0;
          res_full   <= 1'b0;
          res_node   <= '0;
          state      <= S_DONE;
        end

        S_DONE: begin
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          found_q  <= res_found;
          append_q <= res_append;
          full_q   <= res_full;
          node_q   <= res_node;
          state    <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.done_o   = done_q;
  assign bus.append_o = append_q;
  assign bus.found_o  = found_q;
  assign bus.full_o   = full_q;
  assign bus.node_o   = node_q;

endmodule

// File: tb/tb_ht_vote_list.sv
// Directed bench for ht_vote_list: stimulus pushes expected results, a done_o monitor pops and compares.
module tb_ht_vote_list;

  localparam int RHO_W  = 10;
  localparam int CNT_W  = 12;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int N_LIST = 4;
  localparam int LIST_W = 2;
  localparam int NODE_W = CNT_W + RHO_W + ADDR_W;

  typedef struct {
    logic              found;
    logic              app;
    logic              full;
    logic [NODE_W-1:0] node;
    int                done_cyc;
  } exp_t;

  logic clk;
  logic rstn;
  int   cyc;
  int   total;
  int   passed;
  exp_t q[$];

  ht_vote_list_if #(.RHO_W(RHO_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .LIST_W(LIST_W)) bus ();

  ht_vote_list #(
    .RHO_W(RHO_W), .CNT_W(CNT_W), .DEPTH(DEPTH),
    .ADDR_W(ADDR_W), .N_LIST(N_LIST), .LIST_W(LIST_W)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [NODE_W-1:0] mk(input int cnt, input int rho, input int nxt);
    return {CNT_W'(cnt), RHO_W'(rho), ADDR_W'(nxt)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
  endtask

  // Monitor: every done_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rstn && bus.done_o) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("found_o", 64'(bus.found_o), 64'(e.found));
        chk("append_o", 64'(bus.append_o), 64'(e.app));
        chk("full_o", 64'(bus.full_o), 64'(e.full));
        chk("node_o", 64'(bus.node_o), 64'(e.node));
        chk("latency", 64'(cyc), 64'(e.done_cyc));
        chk("busy_at_done", 64'(bus.busy_o), 64'd0);
      end
    end
  end

  task automatic issue(input bit a, input bit s, input bit c, input int lst, input int rho,
                       input bit ef, input bit ea, input bit efull,
                       input logic [NODE_W-1:0] en, input int lat);
    exp_t e;
    @(negedge clk);
    bus.append_i = a;
    bus.search_i = s;
    bus.clear_i  = c;
    bus.list_i   = LIST_W'(lst);
    bus.rho_i    = RHO_W'(rho);
    e.found    = ef;
    e.app      = ea;
    e.full     = efull;
    e.node     = en;
    e.done_cyc = cyc + 1 + lat;
    q.push_back(e);
    @(negedge clk);
    bus.append_i = 1'b0;
    bus.search_i = 1'b0;
    bus.clear_i  = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      total++;
      $display("FAIL timeout: %0d results pending, expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic append(input int lst, input int rho, input bit ef, input bit ea,
                        input bit efull, input logic [NODE_W-1:0] en, input int lat);
    issue(1'b1, 1'b0, 1'b0, lst, rho, ef, ea, efull, en, lat);
    wait_done();
  endtask

  task automatic search(input int lst, input int rho, input bit ef,
                        input logic [NODE_W-1:0] en, input int lat);
    issue(1'b0, 1'b1, 1'b0, lst, rho, ef, 1'b0, 1'b0, en, lat);
    wait_done();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
    chk({tag, "_done"}, 64'(bus.done_o), 64'd0);
    chk({tag, "_append"}, 64'(bus.append_o), 64'd0);
    chk({tag, "_found"}, 64'(bus.found_o), 64'd0);
    chk({tag, "_full"}, 64'(bus.full_o), 64'd0);
    chk({tag, "_node"}, 64'(bus.node_o), 64'd0);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rstn   = 1'b0;
    bus.append_i = 1'b0;
    bus.search_i = 1'b0;
    bus.clear_i  = 1'b0;
    bus.list_i   = '0;
    bus.rho_i    = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rstn = 1'b1;
    @(negedge clk);

    // Basic allocation, vote, tail linking.
    append(0, 123, 1'b0, 1'b1, 1'b0, mk(1, 123, 0), 2);
    append(0, 123, 1'b1, 1'b0, 1'b0, mk(2, 123, 0), 3);
    append(0, 321, 1'b0, 1'b1, 1'b0, mk(1, 321, 1), 3);
    search(0, 123, 1'b1, mk(2, 123, 1), 2);
    search(0, 321, 1'b1, mk(1, 321, 1), 3);
    search(0, 789, 1'b0, '0, 3);
    search(1, 123, 1'b0, '0, 1);

    // append + search together: append wins.
    issue(1'b1, 1'b1, 1'b0, 1, 5, 1'b0, 1'b1, 1'b0, mk(1, 5, 2), 2);
    wait_done();
    search(1, 5, 1'b1, mk(1, 5, 2), 2);

    // Commands pulsed while busy are dropped.
    issue(1'b1, 1'b0, 1'b0, 2, 7, 1'b0, 1'b1, 1'b0, mk(1, 7, 3), 2);
    chk("busy_mid_cmd", 64'(bus.busy_o), 64'd1);
    bus.search_i = 1'b1;
    bus.clear_i  = 1'b1;
    @(negedge clk);
    bus.search_i = 1'b0;
    bus.clear_i  = 1'b0;
    wait_done();
    search(2, 7, 1'b1, mk(1, 7, 3), 2);

    // Counter saturation.
    append(3, 900, 1'b0, 1'b1, 1'b0, mk(1, 900, 4), 2);
    for (int v = 2; v <= 4095; v++) append(3, 900, 1'b1, 1'b0, 1'b0, mk(v, 900, 4), 3);
    append(3, 900, 1'b1, 1'b0, 1'b0, mk(4095, 900, 4), 3);

    // clear + append together: clear wins and empties everything.
    issue(1'b1, 1'b0, 1'b1, 0, 77, 1'b0, 1'b0, 1'b0, '0, 2);
    wait_done();
    search(0, 123, 1'b0, '0, 1);
    search(3, 900, 1'b0, '0, 1);

    // Fill the pool across all lists, then overflow.
    for (int i = 0; i < DEPTH; i++) append(i % N_LIST, i, 1'b0, 1'b1, 1'b0, mk(1, i, i), i / N_LIST + 2);
    append(0, 1000, 1'b0, 1'b0, 1'b1, '0, DEPTH / N_LIST + 2);
    append(0, 0, 1'b1, 1'b0, 1'b0, mk(2, 0, 4), 3);
    search(3, 255, 1'b1, mk(1, 255, 255), DEPTH / N_LIST + 1);
    search(0, 1000, 1'b0, '0, DEPTH / N_LIST + 1);

    // Reset in the middle of a walk over a 5-node list.
    issue(1'b0, 1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0, '0, 2);
    wait_done();
    for (int i = 0; i < 5; i++) append(1, 10 + i, 1'b0, 1'b1, 1'b0, mk(1, 10 + i, i), i + 2);
    issue(1'b0, 1'b1, 1'b0, 1, 14, 1'b1, 1'b0, 1'b0, mk(1, 14, 4), 6);
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    q.delete();
    #1;
    check_all_zero("midwalk_reset");
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    search(1, 10, 1'b0, '0, 1);
    append(1, 55, 1'b0, 1'b1, 1'b0, mk(1, 55, 0), 2);
    search(1, 55, 1'b1, mk(1, 55, 0), 2);

    repeat (5) @(negedge clk);
    chk("pending_results", 64'(q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ht_vote_list.md
Name: ht_vote_list

Overview:
- Parametrised, multi-list successor to the Hough-transform linked list.
- Keeps N_LIST independent singly linked lists, one per theta bin, sharing a node pool of DEPTH entries.
- Each node holds {count, rho, next}:
  - Append on an existing rho casts a vote (saturating count increment).
  - Append on a new rho allocates a node at the list tail.
  - Search returns the node for a rho.
  - Clear empties every list in one cycle.
- Sits between the Hough vote generator and the peak-extraction stage.

Parameters:
- RHO_W, 10, rho width in bits.
- CNT_W, 12, vote counter width in bits; the counter saturates.
- DEPTH, 256, size of the shared node pool.
- ADDR_W, 8, node index width; clog2(DEPTH).
- N_LIST, 4, number of lists (theta bins).
- LIST_W, 2, list select width; clog2(N_LIST).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- list_i  in  LIST_W  target list; sampled at command acceptance.
- rho_i  in  RHO_W  key; sampled at command acceptance.
- append_i  in  1  append/vote request.
- search_i  in  1  search request.
- clear_i  in  1  empty all lists and reset the pool.
- busy_o  out  1  high while a command is in progress; commands are ignored while high.
- done_o  out  1  one-cycle pulse on command completion.
- append_o  out  1  1 = the last append allocated a new node.
- found_o  out  1  1 = rho was present in the list.
- full_o  out  1  an append miss was rejected because the pool was exhausted.
- node_o  out  CNT_W+RHO_W+ADDR_W  {count, rho, next} of the matched or new node; 0 on a miss.

Behaviour:
- Reset (async, rstn=0):
  - State goes to IDLE; all head_valid flags clear; free_ptr=0.
  - busy_o, done_o, append_o, found_o, full_o and node_o all go to 0.
  - Node storage contents are don't-care.
  - Reset mid-walk aborts the command; no partial write may survive.
- Node storage: register array with combinational read and synchronous write.
- End of list: the last node's next field equals its own index.
- Command acceptance:
  - Commands are accepted only in IDLE.
  - Priority when several are asserted: clear > append > search.
  - Acceptance latches list_i and rho_i and raises busy_o on the next cycle.
- State machine: IDLE, WALK, UPDATE, ALLOC, DONE, CLEAR.
  - IDLE -> CLEAR on clear_i.
  - IDLE -> WALK on append_i or search_i.
  - CLEAR (1 cycle): head_valid=0 for all lists, free_ptr=0, then -> DONE with found_o=0 and append_o=0.
  - WALK, on entry: if head_valid[list]=0, go directly to miss handling. Otherwise compare one node per cycle starting at head[list], with cur=next each cycle.
  - WALK hit, append: -> UPDATE.
  - WALK hit, search: -> DONE with found_o=1 and node_o = the node.
  - WALK miss (next==cur), search: -> DONE with found_o=0 and node_o=0.
  - WALK miss, append: -> ALLOC.
  - UPDATE: count <= (count==all-ones) ? count : count+1. Then -> DONE with found_o=1, append_o=0, node_o = updated node.
  - ALLOC when free_ptr==DEPTH: no write; full_o=1, append_o=0, found_o=0, node_o=0; -> DONE.
  - ALLOC otherwise:
    - Write {1, rho, free_ptr} at free_ptr.
    - Link the new node: set the tail's next to free_ptr, or, if the list is empty, set head=free_ptr and head_valid=1.
    - free_ptr++; then -> DONE with append_o=1, found_o=0, node_o = new node.
  - DONE: done_o=1 for one cycle, then -> IDLE; busy_o drops in that same IDLE cycle.
- free_ptr is ADDR_W+1 bits wide; allocation never wraps around.
- append_o, found_o, full_o and node_o are updated only at completion and hold until the next completion.
- Latency (cycles from the acceptance edge to the done_o cycle):
  - search hit at position p (1-based): p+1.
  - search miss on an n-node list: n+1 (empty list: 1).
  - append hit at position p: p+2.
  - append miss: n+2.
  - clear: 2.
- Lists never cross-link; a walk visits only nodes of the selected list.

Test Plan:
- Append list 0, rho 123, to an empty pool -> done_o after 2 cycles; append_o=1, found_o=0, node_o={1,123,0}; free_ptr=1.
- Append list 0, rho 123 again, then rho 321 -> first: found_o=1, append_o=0, count=2. Second: append_o=1, node_o={1,321,1}, and node 0's next becomes 1.
- Search list 0 for 321 -> found_o=1, node_o={1,321,1}, done 3 cycles after acceptance. Search list 0 for 789 -> found_o=0, node_o=0. Search list 1 for 123 -> found_o=0, done after 1 cycle.
- Append 4095 votes on one rho, then 1 more -> count stays 4095. Fill the pool with 256 distinct rho values, then append a new rho -> full_o=1, no write, free_ptr=256.
- Assert append_i and search_i together -> append wins. Assert clear_i with append_i -> clear wins, all lists empty. Pulse commands while busy_o=1 -> ignored.
- Drop rstn during a 5-node walk -> all outputs 0 immediately. After release, a search on that list finds nothing, and the first append uses node 0.
